sha1_ctrl: RTL

//  Sequencer for the sha1block compression core. Accepts pre-padded message words as a

---
 rtl/sha1_pkg.sv | 31 +++
 rtl/sha1_wbuf.sv | 46 ++++
 rtl/sha1_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 block sequencer: word type, FSM states,
// the initial chaining value and a lane-wise adder for the chaining update.
package sha1_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        WAITC = 3'd0,
        FILL  = 3'd1,
        START = 3'd2,
        LOAD  = 3'd3,
        RUN   = 3'd4
    } state_t;

    localparam word_t IV0 = 32'h67452301;
    localparam word_t IV1 = 32'hefcdab89;
    localparam word_t IV2 = 32'h98badcfe;
    localparam word_t IV3 = 32'h10325476;
    localparam word_t IV4 = 32'hc3d2e1f0;
    localparam logic [159:0] IV = {IV0, IV1, IV2, IV3, IV4};

    // Five independent 32-bit additions, each wrapping mod 2^32
    function automatic logic [159:0] add_lanes(input logic [159:0] a, input logic [159:0] b);
        logic [159:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha1_wbuf.sv
// One-block message buffer: 16x32 register file with a synchronous write port and an
// asynchronous read port, plus the first/last flags captured with words 0 and 15.
module sha1_wbuf
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        wfirst,
    input  logic        wlast,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata,
    output logic        staged_first,
    output logic        staged_last
);

    word_t mem_r [16];
    logic  first_r;
    logic  last_r;

    // Word storage and the block flags that travel with positions 0 and 15
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            first_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (we) begin
            mem_r[waddr] <= wdata;
            if (waddr == 4'd0) begin
                first_r <= wfirst;
            end
            if (waddr == 4'd15) begin
                last_r <= wlast;
            end
        end
    end

    assign rdata        = mem_r[raddr];
    assign staged_first = first_r;
    assign staged_last  = last_r;

endmodule

// File: rtl/sha1_ctrl.sv
// Sequencer for the sha1block compression core: buffers a block, restarts the core,
// accumulates the chaining value and emits the digest after a message's last block.
module sha1_ctrl
    import sha1_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [31:0]   s_data,
    input  logic          s_first,
    input  logic          s_last,
    output logic          core_restart,
    output logic [159:0]  core_h,
    output logic [31:0]   core_in,
    input  logic [3:0]    core_raddr,
    input  logic          core_ready,
    input  logic [159:0]  core_abcde,
    output logic [159:0]  digest,
    output logic          digest_valid,
    output logic          busy
);

    state_t         state_r;
    state_t         state_s;
    logic [4:0]     wcnt_r;
    logic [3:0]     lcnt_r;
    logic [159:0]   h_r;
    logic           first_pend_r;
    logic           last_pend_r;
    logic [159:0]   digest_r;
    logic           digest_valid_r;
    logic           accept_s;
    logic           word15_s;
    logic           core_done_s;
    logic           staged_first_s;
    logic           staged_last_s;
    logic [159:0]   base_s;
    logic [159:0]   sum_s;

    sha1_wbuf u_wbuf (
        .clk          (clk),
        .rst          (rst),
        .we           (accept_s),
        .waddr        (wcnt_r[3:0]),
        .wdata        (s_data),
        .wfirst       (s_first),
        .wlast        (s_last),
        .raddr        (core_raddr),
        .rdata        (core_in),
        .staged_first (staged_first_s),
        .staged_last  (staged_last_s)
    );

    assign accept_s    = s_valid && s_ready;
    assign word15_s    = accept_s && (wcnt_r == 5'd15);
    assign core_done_s = (state_r == RUN) && core_ready;
    // A message's first block chains from IV regardless of what H holds
    assign base_s      = first_pend_r ? IV : h_r;
    assign sum_s       = add_lanes(base_s, core_abcde);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAITC;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; core_ready is only honoured in WAITC and RUN
    always_comb begin
        state_s = state_r;
        case (state_r)
            WAITC:   if (core_ready) state_s = FILL;  else state_s = WAITC;
            FILL:    if (word15_s)   state_s = START; else state_s = FILL;
            START:   state_s = LOAD;
            LOAD:    if (lcnt_r == 4'd15) state_s = RUN; else state_s = LOAD;
            RUN: begin
                if (core_ready) begin
                    if ((wcnt_r == 5'd16) || word15_s) state_s = START;
                    else                               state_s = FILL;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = WAITC;
        endcase
    end

    // Moore outputs: stream ready and the one-cycle core restart
    always_comb begin
        s_ready      = 1'b0;
        core_restart = 1'b0;
        case (state_r)
            FILL:    s_ready = (wcnt_r < 5'd16);
            START:   core_restart = 1'b1;
            RUN:     s_ready = OVERLAP && (wcnt_r < 5'd16);
            default: begin
                s_ready      = 1'b0;
                core_restart = 1'b0;
            end
        endcase
    end

    // Counters, active-block flags, chaining value and digest
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_r         <= 5'd0;
            lcnt_r         <= 4'd0;
            h_r            <= IV;
            first_pend_r   <= 1'b0;
            last_pend_r    <= 1'b0;
            digest_r       <= 160'd0;
            digest_valid_r <= 1'b0;
        end else begin
            digest_valid_r <= 1'b0;
            if (accept_s) begin
                wcnt_r <= wcnt_r + 5'd1;
            end else if ((state_r == LOAD) && (lcnt_r == 4'd15)) begin
                wcnt_r <= 5'd0;
            end
            if (state_r == START) begin
                lcnt_r <= 4'd0;
            end else if (state_r == LOAD) begin
                lcnt_r <= lcnt_r + 4'd1;
            end
            // word 15 may land in the same cycle we move to START, so bypass its flag
            if (state_s == START) begin
                first_pend_r <= staged_first_s;
                last_pend_r  <= word15_s ? s_last : staged_last_s;
            end
            if (core_done_s) begin
                h_r <= sum_s;
                if (last_pend_r) begin
                    digest_r       <= sum_s;
                    digest_valid_r <= 1'b1;
                end
            end
        end
    end

    assign core_h       = base_s;
    assign digest       = digest_r;
    assign digest_valid = digest_valid_r;
    assign busy         = (state_r != FILL) || (wcnt_r != 5'd0);

endmodule
